multicycle_control: RTL and testbench

Multi-cycle successor to the single-cycle main control unit of the MIPS datapath. A Moore state machine sequences each instruction over 3-5 cycles (fetch, decode, execute, memory, writeback) and drives the shared-ALU / single-memory multi-cycle datapath. Memory accesses wait on a ready handshake, and ALUOp width is parametrised. Adds BNE, J/JAL and illegal-opcode detection, which the single-cycle unit lacks.

---
 rtl/multicycle_control.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath. A Moore machine steps each
// instruction through fetch/decode/execute/memory/writeback. It waits on i_mem_ready
// for memory accesses and flags unrecognised opcodes on o_illegal.
module multicycle_control #(
    parameter int unsigned ALUOP_W      = 4,    // must be >= 4
    parameter bit          SUPPORT_JUMP = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [5:0]         i_op,
    input  logic               i_mem_ready,
    output logic               o_pc_write,
    output logic               o_pc_write_cond,
    output logic               o_branch_ne,
    output logic               o_ior_d,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_ir_write,
    output logic               o_alu_src_a,
    output logic               o_reg_write,
    output logic [1:0]         o_reg_dst,
    output logic [1:0]         o_mem_to_reg,
    output logic [1:0]         o_alu_src_b,
    output logic [1:0]         o_pc_source,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_illegal,
    output logic [3:0]         o_state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StIExec  = 4'd9,
        StIwb    = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpLb    = 6'b100000;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpSb    = 6'b101000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpSltiu = 6'b001011;

    state_e     r_state;
    state_e     w_state_next;
    logic [5:0] r_op;
    logic [3:0] w_icode;
    logic [3:0] w_alu_op4;

    // State register and opcode latch; the opcode is captured only while decoding
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StFetch;
            r_op    <= 6'b000000;
        end else begin
            r_state <= w_state_next;
            if (r_state == StDecode) begin
                r_op <= i_op;
            end
        end
    end

    // ALU operation for the I-type arithmetic/logic instructions, from the latched opcode
    always_comb begin
        w_icode = 4'b0000;
        case (r_op)
            OpAddi:  w_icode = 4'b0100;
            OpAddiu: w_icode = 4'b0101;
            OpAndi:  w_icode = 4'b0110;
            OpOri:   w_icode = 4'b0111;
            OpXori:  w_icode = 4'b1000;
            OpSlti:  w_icode = 4'b1001;
            OpSltiu: w_icode = 4'b1010;
            default: w_icode = 4'b0000;
        endcase
    end

    // Next-state and Moore outputs; reset forces every output low without waiting for a clock
    always_comb begin
        w_state_next    = StFetch;
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_branch_ne     = 1'b0;
        o_ior_d         = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_alu_src_a     = 1'b0;
        o_reg_write     = 1'b0;
        o_reg_dst       = 2'b00;
        o_mem_to_reg    = 2'b00;
        o_alu_src_b     = 2'b00;
        o_pc_source     = 2'b00;
        w_alu_op4       = 4'b0000;
        o_illegal       = 1'b0;
        o_state         = r_state;

        case (r_state)
            StFetch: begin
                o_mem_read   = 1'b1;
                o_alu_src_b  = 2'b01;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
                w_state_next = i_mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                o_alu_src_b = 2'b11;
                case (i_op)
                    OpRType:                   w_state_next = StExec;
                    OpLw, OpLb, OpSw, OpSb:    w_state_next = StMemAdr;
                    OpBeq, OpBne:              w_state_next = StBranch;
                    OpAddi, OpAddiu, OpAndi, OpOri, OpXori, OpSlti, OpSltiu:
                                               w_state_next = StIExec;
                    OpJ, OpJal: begin
                        if (SUPPORT_JUMP) begin
                            w_state_next = StJump;
                        end else begin
                            o_illegal = 1'b1;
                        end
                    end
                    default:                   o_illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                o_alu_src_a  = 1'b1;
                o_alu_src_b  = 2'b10;
                w_state_next = (r_op == OpSw || r_op == OpSb) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                o_mem_read   = 1'b1;
                o_ior_d      = 1'b1;
                w_state_next = i_mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                o_mem_to_reg = 2'b01;
                o_reg_write  = 1'b1;
            end
            StMemWr: begin
                o_mem_write  = 1'b1;
                o_ior_d      = 1'b1;
                w_state_next = i_mem_ready ? StFetch : StMemWr;
            end
            StExec: begin
                o_alu_src_a  = 1'b1;
                w_alu_op4    = 4'b0010;
                w_state_next = StRwb;
            end
            StRwb: begin
                o_reg_dst   = 2'b01;
                o_reg_write = 1'b1;
            end
            StBranch: begin
                o_alu_src_a     = 1'b1;
                w_alu_op4       = 4'b0001;
                o_pc_write_cond = 1'b1;
                o_pc_source     = 2'b01;
                o_branch_ne     = (r_op == OpBne);
            end
            StIExec: begin
                o_alu_src_a  = 1'b1;
                o_alu_src_b  = 2'b10;
                w_alu_op4    = w_icode;
                w_state_next = StIwb;
            end
            StIwb: begin
                o_reg_write = 1'b1;
                w_alu_op4   = w_icode;
            end
            StJump: begin
                o_pc_write  = 1'b1;
                o_pc_source = 2'b10;
                if (r_op == OpJal) begin
                    o_reg_write  = 1'b1;
                    o_reg_dst    = 2'b10;
                    o_mem_to_reg = 2'b10;
                end
            end
            default: begin
                // Unused encodings recover to fetch with everything idle
                o_state = r_state;
            end
        endcase

        o_alu_op = ALUOP_W'(w_alu_op4);

        if (i_rst) begin
            w_state_next    = StFetch;
            o_pc_write      = 1'b0;
            o_pc_write_cond = 1'b0;
            o_branch_ne     = 1'b0;
            o_ior_d         = 1'b0;
            o_mem_read      = 1'b0;
            o_mem_write     = 1'b0;
            o_ir_write      = 1'b0;
            o_alu_src_a     = 1'b0;
            o_reg_write     = 1'b0;
            o_reg_dst       = 2'b00;
            o_mem_to_reg    = 2'b00;
            o_alu_src_b     = 2'b00;
            o_pc_source     = 2'b00;
            o_alu_op        = '0;
            o_illegal       = 1'b0;
            o_state         = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (jumps on with 4-bit ALUOp, jumps off with
// 6-bit ALUOp) are driven by their own inputs. Each instance is checked every cycle against
// a model that plans per-instruction state sequences from the instruction class.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [5:0] alu_op;
        logic       illegal;
        logic [3:0] state;
    } ctl_t;

    typedef struct {
        int   dut;
        int   cyc;
        ctl_t e;
        ctl_t a;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op0, op1;
    logic       mr0, mr1;

    logic       pw0, pwc0, bne0, iord0, mrd0, mwr0, irw0, asa0, rw0, ill0;
    logic [1:0] rdst0, m2r0, asb0, psrc0;
    logic [3:0] alu0, st0;
    logic       pw1, pwc1, bne1, iord1, mrd1, mwr1, irw1, asa1, rw1, ill1;
    logic [1:0] rdst1, m2r1, asb1, psrc1;
    logic [5:0] alu1;
    logic [3:0] st1;

    ctl_t act0, act1;
    assign act0 = {pw0, pwc0, bne0, iord0, mrd0, mwr0, irw0, asa0, rw0,
                   rdst0, m2r0, asb0, psrc0, 6'(alu0), ill0, st0};
    assign act1 = {pw1, pwc1, bne1, iord1, mrd1, mwr1, irw1, asa1, rw1,
                   rdst1, m2r1, asb1, psrc1, alu1, ill1, st1};

    int   n_vec = 0;
    int   n_err = 0;
    rec_t recs[$];
    int   pst0[$], pst1[$];
    logic pmr0[$], pmr1[$];
    logic [5:0] pool [0:15];

    always #5 clk = ~clk;

    multicycle_control #(.ALUOP_W(4), .SUPPORT_JUMP(1'b1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_op(op0), .i_mem_ready(mr0),
        .o_pc_write(pw0), .o_pc_write_cond(pwc0), .o_branch_ne(bne0), .o_ior_d(iord0),
        .o_mem_read(mrd0), .o_mem_write(mwr0), .o_ir_write(irw0), .o_alu_src_a(asa0),
        .o_reg_write(rw0), .o_reg_dst(rdst0), .o_mem_to_reg(m2r0), .o_alu_src_b(asb0),
        .o_pc_source(psrc0), .o_alu_op(alu0), .o_illegal(ill0), .o_state(st0)
    );

    multicycle_control #(.ALUOP_W(6), .SUPPORT_JUMP(1'b0)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_op(op1), .i_mem_ready(mr1),
        .o_pc_write(pw1), .o_pc_write_cond(pwc1), .o_branch_ne(bne1), .o_ior_d(iord1),
        .o_mem_read(mrd1), .o_mem_write(mwr1), .o_ir_write(irw1), .o_alu_src_a(asa1),
        .o_reg_write(rw1), .o_reg_dst(rdst1), .o_mem_to_reg(m2r1), .o_alu_src_b(asb1),
        .o_pc_source(psrc1), .o_alu_op(alu1), .o_illegal(ill1), .o_state(st1)
    );

    // Instruction class: 0 illegal, 1 R-type, 2 load, 3 store, 4 branch, 5 I-ALU, 6 jump
    function automatic int op_class(input logic [5:0] op, input logic sj);
        case (op)
            6'b000000:                         return 1;
            6'b100011, 6'b100000:              return 2;
            6'b101011, 6'b101000:              return 3;
            6'b000100, 6'b000101:              return 4;
            6'b001000, 6'b001001, 6'b001100, 6'b001101,
            6'b001110, 6'b001010, 6'b001011:   return 5;
            6'b000010, 6'b000011:              return sj ? 6 : 0;
            default:                           return 0;
        endcase
    endfunction

    function automatic logic [5:0] icode(input logic [5:0] op);
        case (op)
            6'b001000: return 6'd4;   // ADDI
            6'b001001: return 6'd5;   // ADDIU
            6'b001100: return 6'd6;   // ANDI
            6'b001101: return 6'd7;   // ORI
            6'b001110: return 6'd8;   // XORI
            6'b001010: return 6'd9;   // SLTI
            6'b001011: return 6'd10;  // SLTIU
            default:   return 6'd0;
        endcase
    endfunction

    // Expected control word for a state number, instruction opcode and MemReady value
    function automatic ctl_t exp_vec(input int st, input logic [5:0] op, input logic mr,
                                     input logic sj);
        ctl_t c;
        c = '0;
        c.state = 4'(st);
        case (st)
            0:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01;
                      c.ir_write = mr; c.pc_write = mr; end
            1:  begin c.alu_src_b = 2'b11; c.illegal = (op_class(op, sj) == 0); end
            2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            3:  begin c.mem_read = 1'b1; c.ior_d = 1'b1; end
            4:  begin c.mem_to_reg = 2'b01; c.reg_write = 1'b1; end
            5:  begin c.mem_write = 1'b1; c.ior_d = 1'b1; end
            6:  begin c.alu_src_a = 1'b1; c.alu_op = 6'd2; end
            7:  begin c.reg_dst = 2'b01; c.reg_write = 1'b1; end
            8:  begin c.alu_src_a = 1'b1; c.alu_op = 6'd1; c.pc_write_cond = 1'b1;
                      c.pc_source = 2'b01; c.branch_ne = (op == 6'b000101); end
            9:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = icode(op); end
            10: begin c.reg_write = 1'b1; c.alu_op = icode(op); end
            11: begin c.pc_write = 1'b1; c.pc_source = 2'b10;
                      if (op == 6'b000011) begin
                          c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
                      end
                end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic plan_push(input int d, input int st, input logic mr);
        if (d == 0) begin pst0.push_back(st); pmr0.push_back(mr); end
        else        begin pst1.push_back(st); pmr1.push_back(mr); end
    endtask

    // Cycle-by-cycle plan of one instruction from its class, with fs fetch and ms memory stalls
    task automatic plan_instr(input int d, input logic [5:0] op, input int fs, input int ms);
        int cls;
        cls = op_class(op, d == 0);
        repeat (fs) plan_push(d, 0, 1'b0);
        plan_push(d, 0, 1'b1);
        plan_push(d, 1, 1'($urandom));
        case (cls)
            1: begin plan_push(d, 6, 1'($urandom)); plan_push(d, 7, 1'($urandom)); end
            2: begin
                plan_push(d, 2, 1'($urandom));
                repeat (ms) plan_push(d, 3, 1'b0);
                plan_push(d, 3, 1'b1);
                plan_push(d, 4, 1'($urandom));
            end
            3: begin
                plan_push(d, 2, 1'($urandom));
                repeat (ms) plan_push(d, 5, 1'b0);
                plan_push(d, 5, 1'b1);
            end
            4: plan_push(d, 8, 1'($urandom));
            5: begin plan_push(d, 9, 1'($urandom)); plan_push(d, 10, 1'($urandom)); end
            6: plan_push(d, 11, 1'($urandom));
            default: ;
        endcase
    endtask

    // Run one instruction on both instances (shorter plan padded with extra fetch stalls)
    // and record actual against expected for each cycle.
    task automatic apply_instr(input logic [5:0] op, input int fs, input int ms);
        rec_t r;
        pst0.delete(); pst1.delete(); pmr0.delete(); pmr1.delete();
        plan_instr(0, op, fs, ms);
        plan_instr(1, op, fs, ms);
        while (pst0.size() < pst1.size()) begin pst0.push_front(0); pmr0.push_front(1'b0); end
        while (pst1.size() < pst0.size()) begin pst1.push_front(0); pmr1.push_front(1'b0); end
        for (int i = 0; i < pst0.size(); i++) begin
            mr0 = pmr0[i];
            mr1 = pmr1[i];
            op0 = (pst0[i] == 1) ? op : 6'($urandom);
            op1 = (pst1[i] == 1) ? op : 6'($urandom);
            @(negedge clk);
            r.cyc = i;
            r.dut = 0; r.e = exp_vec(pst0[i], op, pmr0[i], 1'b1); r.a = act0; recs.push_back(r);
            r.dut = 1; r.e = exp_vec(pst1[i], op, pmr1[i], 1'b0); r.a = act1; recs.push_back(r);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        ctl_t e;
        #1 rst = 1'b1;
        mr0 = 1'b1; mr1 = 1'b1; op0 = 6'($urandom); op1 = 6'($urandom);
        #1;
        n_vec++;
        if (act0 !== '0 || act1 !== '0) begin
            n_err++;
            $display("FAIL reset_async: got %h/%h expected 0", act0, act1);
        end
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (act0 !== '0 || act1 !== '0) begin
                n_err++;
                $display("FAIL reset_hold: got %h/%h expected 0", act0, act1);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; mr0 = 1'b0; mr1 = 1'b0;
        @(negedge clk);
        e = exp_vec(0, 6'd0, 1'b0, 1'b1);
        n_vec++;
        if (act0 !== e || act1 !== e) begin
            n_err++;
            $display("FAIL reset_release: got %h/%h expected %h", act0, act1, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype;
        apply_instr(6'b000000, 0, 0);
        apply_instr(6'b000000, 2, 0);
        foreach (recs[i]) begin
            n_vec++;
            if (recs[i].a !== recs[i].e) begin
                n_err++;
                $display("FAIL rtype dut%0d cyc %0d: got %h expected %h",
                         recs[i].dut, recs[i].cyc, recs[i].a, recs[i].e);
            end
        end
        recs.delete();
    endtask

    task automatic test_load_store;
        apply_instr(6'b100011, 0, 2);  // LW with two memory wait cycles
        apply_instr(6'b100000, 1, 0);  // LB
        apply_instr(6'b101011, 0, 1);  // SW
        apply_instr(6'b101000, 0, 0);  // SB
        foreach (recs[i]) begin
            n_vec++;
            if (recs[i].a !== recs[i].e) begin
                n_err++;
                $display("FAIL load_store dut%0d cyc %0d: got %h expected %h",
                         recs[i].dut, recs[i].cyc, recs[i].a, recs[i].e);
            end
        end
        recs.delete();
    endtask

    task automatic test_branch;
        apply_instr(6'b000101, 0, 0);  // BNE
        apply_instr(6'b000100, 0, 0);  // BEQ
        foreach (recs[i]) begin
            n_vec++;
            if (recs[i].a !== recs[i].e) begin
                n_err++;
                $display("FAIL branch dut%0d cyc %0d: got %h expected %h",
                         recs[i].dut, recs[i].cyc, recs[i].a, recs[i].e);
            end
        end
        recs.delete();
    endtask

    task automatic test_itype;
        logic [5:0] ops [0:6];
        ops[0] = 6'b001000; ops[1] = 6'b001001; ops[2] = 6'b001100; ops[3] = 6'b001101;
        ops[4] = 6'b001110; ops[5] = 6'b001010; ops[6] = 6'b001011;
        for (int k = 0; k < 7; k++) apply_instr(ops[k], 0, 0);
        foreach (recs[i]) begin
            n_vec++;
            if (recs[i].a !== recs[i].e) begin
                n_err++;
                $display("FAIL itype dut%0d cyc %0d: got %h expected %h",
                         recs[i].dut, recs[i].cyc, recs[i].a, recs[i].e);
            end
        end
        recs.delete();
    endtask

    task automatic test_jump_illegal;
        apply_instr(6'b000011, 0, 0);  // JAL
        apply_instr(6'b000010, 0, 0);  // J
        apply_instr(6'b111111, 0, 0);
        apply_instr(6'b000001, 1, 0);
        foreach (recs[i]) begin
            n_vec++;
            if (recs[i].a !== recs[i].e) begin
                n_err++;
                $display("FAIL jump_illegal dut%0d cyc %0d: got %h expected %h",
                         recs[i].dut, recs[i].cyc, recs[i].a, recs[i].e);
            end
        end
        recs.delete();
    endtask

    task automatic test_back_to_back;
        logic [5:0] op;
        pool[0]  = 6'b000000; pool[1]  = 6'b100011; pool[2]  = 6'b100000; pool[3]  = 6'b101011;
        pool[4]  = 6'b101000; pool[5]  = 6'b000100; pool[6]  = 6'b000101; pool[7]  = 6'b001000;
        pool[8]  = 6'b001001; pool[9]  = 6'b001100; pool[10] = 6'b001101; pool[11] = 6'b001110;
        pool[12] = 6'b001010; pool[13] = 6'b001011; pool[14] = 6'b000010; pool[15] = 6'b000011;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else                           op = pool[$urandom_range(0, 15)];
            apply_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        foreach (recs[i]) begin
            n_vec++;
            if (recs[i].a !== recs[i].e) begin
                n_err++;
                $display("FAIL back_to_back dut%0d cyc %0d: got %h expected %h",
                         recs[i].dut, recs[i].cyc, recs[i].a, recs[i].e);
            end
        end
        recs.delete();
    endtask

    task automatic test_reset_mid_memrd;
        ctl_t e;
        op0 = 6'b100011; op1 = 6'b100011; mr0 = 1'b1; mr1 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end   // FETCH -> DECODE -> MEMADR -> MEMRD
        mr0 = 1'b0; mr1 = 1'b0;
        @(negedge clk);
        e = exp_vec(3, 6'b100011, 1'b0, 1'b1);
        n_vec++;
        if (act0 !== e || act1 !== e) begin
            n_err++;
            $display("FAIL memrd_entry: got %h/%h expected %h", act0, act1, e);
        end
        #2 rst = 1'b1;
        mr0 = 1'b1; mr1 = 1'b1;
        #1;
        n_vec++;
        if (act0 !== '0 || act1 !== '0) begin
            n_err++;
            $display("FAIL memrd_abort: got %h/%h expected 0", act0, act1);
        end
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (act0 !== '0 || act1 !== '0) begin
                n_err++;
                $display("FAIL memrd_reset_hold: got %h/%h expected 0", act0, act1);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; mr0 = 1'b0; mr1 = 1'b0;
        @(negedge clk);
        e = exp_vec(0, 6'd0, 1'b0, 1'b1);
        n_vec++;
        if (act0 !== e || act1 !== e) begin
            n_err++;
            $display("FAIL memrd_release: got %h/%h expected %h", act0, act1, e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        op0 = 6'd0; op1 = 6'd0; mr0 = 1'b0; mr1 = 1'b0;
        test_reset();
        test_rtype();
        test_load_store();
        test_branch();
        test_itype();
        test_jump_illegal();
        test_back_to_back();
        test_reset_mid_memrd();
        test_rtype();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
